aes128_key_expand: RTL and testbench
====================================

AES128_KEY_EXPAND -- requirements
Module: aes128_key_expand

Interface
REQ-001 Parameter ZEROIZE_ON_START, default 1, meaning: when 1, a new start clears all stored round keys 1..10 to zero before expansion.
REQ-002 clk  input  1  Clock; all state updates on rising edge.
REQ-003 rst  input  1  Reset; synchronous, active-high.
REQ-004 start  input  1  Request expansion of key; sampled only when busy=0.
REQ-005 key  input  128  Cipher key; FIPS-197 byte order, key[127:96] = w0.
REQ-006 busy  output  1  Expansion in progress.
REQ-007 key_valid  output  1  All 11 round keys are complete and readable.
REQ-008 rk_idx  input  4  Round key read index, 0..10.
REQ-009 rk_out  output  128  Registered round key read data.
REQ-010 rk_err  output  1  Registered flag: last read index was out of range or the read was blocked.

Function
REQ-011 The block SHALL implement a standards-compliant FIPS-197 AES-128 key schedule: true AES S-box (LUT or GF(2^8) inverse plus affine), RotWord, Rcon = 01,02,04,08,10,20,40,80,1b,36.
REQ-012 Round key i+1 SHALL be computed from round key i only: w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon[i],24'h0}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-013 FSM states: IDLE, EXPAND; IDLE->EXPAND on start; EXPAND->IDLE after round key 10 is written.
REQ-014 On the edge sampling start=1 in IDLE (edge k), rk[0] <= key, round counter <= 1, busy <= 1, key_valid <= 0; if ZEROIZE_ON_START=1, rk[1..10] <= 0.
REQ-015 rk[i] SHALL be written at edge k+i for i = 1..10, one round key per cycle.
REQ-016 At edge k+10, key_valid <= 1 and busy <= 0 on the same edge; the total latency from start to key_valid is 10 cycles.
REQ-017 start while busy=1 SHALL be ignored: key is not re-sampled and the schedule in progress is unaffected.
REQ-018 start in IDLE while key_valid=1 SHALL restart expansion per REQ-014, dropping key_valid at edge k.
REQ-019 Read port: at every edge, if key_valid=1 and rk_idx<=10, then rk_out <= rk[rk_idx] and rk_err <= 0; otherwise rk_out <= 0 and rk_err <= 1.
REQ-020 Partial or intermediate round keys SHALL never appear on rk_out.
REQ-021 The round counter SHALL be 4 bits and SHALL NOT advance past 10; it does not wrap.

Reset
REQ-022 While rst=1, at each edge: state <= IDLE, busy <= 0, key_valid <= 0, rk_out <= 0, rk_err <= 0, and rk[0..10] <= 0.
REQ-023 rst asserted mid-expansion SHALL abort the expansion and apply REQ-022; the aborted key is not recoverable afterwards.
REQ-024 rst SHALL take priority over start on the same edge.

Verification
REQ-025 FIPS-197 A.1: start with key=2b7e151628aed2a6abf7158809cf4f3c -> key_valid=1 ten cycles later; rk_idx=1 gives rk_out=a0fafe1788542cb123a339392a6c7605; rk_idx=10 gives rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-026 Key=0: read rk_idx=1 -> 62636363626363636263636362636363; read rk_idx=10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-027 Pulse start again at cycle k+3 with a different key -> it is ignored; the final keys match the first key and busy stays high exactly 10 cycles.
REQ-028 Read rk_idx=4 with key_valid=0 during expansion, and read rk_idx=11 or 15 after completion -> rk_out=0 and rk_err=1 one cycle later.
REQ-029 Assert rst at cycle k+5 -> the next edge gives busy=0 and key_valid=0; all reads return 0 with rk_err=1; a new start with the A.1 key then completes correctly.
REQ-030 Restart after valid with key=0 -> key_valid falls at edge k; rk_idx=10 read at k+1 returns 0 with rk_err=1; after k+10, the values are those of REQ-026.

Source files
------------

// File: rtl/aes128_key_expand_if.sv
// Bus bundle for the AES-128 key expansion block: the start/key request,
// busy/key_valid status, and the registered round-key read port.
interface aes128_key_expand_if;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         key_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         rk_err;

  // The requester drives start/key/rk_idx and observes status and read data
  modport master (
    output start,
    output key,
    output rk_idx,
    input  busy,
    input  key_valid,
    input  rk_out,
    input  rk_err
  );

  // The key expansion block consumes requests and produces status and read data
  modport slave (
    input  start,
    input  key,
    input  rk_idx,
    output busy,
    output key_valid,
    output rk_out,
    output rk_err
  );
endinterface

// File: rtl/aes128_key_expand.sv
// AES-128 key schedule (FIPS-197). A start request captures the cipher key as
// round key 0 and then derives one round key per cycle from the previous one,
// storing all eleven round keys. A registered read port returns a stored round
// key only once the whole schedule is complete, so partially built schedules
// are never visible.
module aes128_key_expand #(
  parameter bit ZEROIZE_ON_START = 1'b1
) (
  input logic              clk,
  input logic              rst,
  aes128_key_expand_if.slave bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] EXPAND = 1'b1;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // Forward AES S-box, indexed by the input byte
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Apply the S-box to each byte of a 32-bit word
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Round constant used when deriving round key r from round key r-1
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  logic [0:0]   state;
  logic [3:0]   round;
  logic         busy;
  logic         key_valid;
  logic [127:0] rk_out;
  logic         rk_err;
  logic [127:0] rk [0:10];

  logic [3:0]   prev_idx;
  logic [127:0] prev_key;
  logic [31:0]  temp;
  logic [31:0]  nw0;
  logic [31:0]  nw1;
  logic [31:0]  nw2;
  logic [31:0]  nw3;
  logic [127:0] next_key;

  assign bus.busy      = busy;
  assign bus.key_valid = key_valid;
  assign bus.rk_out    = rk_out;
  assign bus.rk_err    = rk_err;

  // Derive the round key being written this cycle from the one stored just before it
  always_comb begin
    prev_idx = (round == 4'd0) ? 4'd0 : round - 4'd1;
    prev_key = rk[prev_idx];
    temp     = sub_word({prev_key[23:0], prev_key[31:24]}) ^ {rcon(round), 24'h0};
    nw0      = prev_key[127:96] ^ temp;
    nw1      = prev_key[95:64] ^ nw0;
    nw2      = prev_key[63:32] ^ nw1;
    nw3      = prev_key[31:0] ^ nw2;
    next_key = {nw0, nw1, nw2, nw3};
  end

  // Control FSM and round key storage: capture the key on start, then fill one round key per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      round     <= 4'd0;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      for (int i = 0; i <= 10; i++) begin
        rk[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= EXPAND;
            round     <= 4'd1;
            busy      <= 1'b1;
            key_valid <= 1'b0;
            rk[0]     <= bus.key;
            if (ZEROIZE_ON_START) begin
              for (int i = 1; i <= 10; i++) begin
                rk[i] <= '0;
              end
            end
          end
        end
        EXPAND: begin
          rk[round] <= next_key;
          if (round == LAST_ROUND) begin
            state     <= IDLE;
            busy      <= 1'b0;
            key_valid <= 1'b1;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Registered read port: only a complete schedule and an in-range index return data
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_out <= '0;
      rk_err <= 1'b0;
    end else if (key_valid && (bus.rk_idx <= LAST_ROUND)) begin
      rk_out <= rk[bus.rk_idx];
      rk_err <= 1'b0;
    end else begin
      rk_out <= '0;
      rk_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes128_key_expand.sv
// Self-checking bench for aes128_key_expand: directed FIPS-197 vectors, busy
// restart/abort scenarios, and random keys compared against a word-recurrence
// key schedule model built on a GF(2^8)-derived S-box.
module tb_aes128_key_expand;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cycle_count;
  int   busy_count;
  int   start_cycle;

  logic [7:0]   sbox_ref [0:255];
  logic [127:0] key_a1;
  logic [127:0] key_rand;

  aes128_key_expand_if bus ();

  aes128_key_expand #(.ZEROIZE_ON_START(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_ref[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    end
  endtask

  // Key schedule via the FIPS-197 word recurrence w[i] = w[i-4] ^ temp
  function automatic logic [127:0] ref_round_key(input logic [127:0] k, input int idx);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = k[127:96];
    w[1] = k[95:64];
    w[2] = k[63:32];
    w[3] = k[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample just after it
  task automatic tick();
    @(posedge clk);
    #1;
    cycle_count++;
    if (bus.busy === 1'b1) busy_count++;
  endtask

  // Pulse start for one edge with the given key (edge k)
  task automatic apply_stimulus(input logic [127:0] k);
    bus.key   = k;
    bus.start = 1'b1;
    busy_count = 0;
    tick();
    start_cycle = cycle_count;
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for key_valid, then check latency and busy duration
  task automatic wait_done(input string tag);
    while (bus.key_valid !== 1'b1 && (cycle_count - start_cycle) < 30) tick();
    check_output({tag, "_latency"}, 128'(cycle_count - start_cycle), 128'd10);
    check_output({tag, "_busy_cycles"}, 128'(busy_count), 128'd10);
    check_output({tag, "_busy_low"}, 128'(bus.busy), 128'd0);
  endtask

  task automatic read_rk(input logic [3:0] idx);
    bus.rk_idx = idx;
    tick();
  endtask

  // Read all round keys and compare against the model
  task automatic check_all(input string tag, input logic [127:0] k);
    for (int i = 0; i <= 10; i++) begin
      read_rk(4'(i));
      check_output($sformatf("%s_rk%0d", tag, i), bus.rk_out, ref_round_key(k, i));
      check_output($sformatf("%s_err%0d", tag, i), 128'(bus.rk_err), 128'd0);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cycle_count = 0;
    busy_count  = 0;
    start_cycle = 0;
    key_a1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.key     = '0;
    bus.rk_idx  = 4'd0;
    build_sbox();

    // Reset state
    tick();
    tick();
    check_output("rst_busy", 128'(bus.busy), 128'd0);
    check_output("rst_valid", 128'(bus.key_valid), 128'd0);
    check_output("rst_rk_out", bus.rk_out, 128'd0);
    check_output("rst_rk_err", 128'(bus.rk_err), 128'd0);
    rst = 1'b0;

    // FIPS-197 A.1 key, read during expansion, ignored start at k+3
    bus.rk_idx = 4'd4;
    apply_stimulus(key_a1);
    check_output("a1_busy_k", 128'(bus.busy), 128'd1);
    check_output("a1_valid_k", 128'(bus.key_valid), 128'd0);
    tick();
    check_output("a1_busy_read_out", bus.rk_out, 128'd0);
    check_output("a1_busy_read_err", 128'(bus.rk_err), 128'd1);
    tick();
    bus.key   = {$urandom, $urandom, $urandom, $urandom};
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("a1");
    check_all("a1", key_a1);
    read_rk(4'd1);
    check_output("a1_vec_rk1", bus.rk_out, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk(4'd10);
    check_output("a1_vec_rk10", bus.rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk(4'd11);
    check_output("oor11_out", bus.rk_out, 128'd0);
    check_output("oor11_err", 128'(bus.rk_err), 128'd1);
    read_rk(4'd15);
    check_output("oor15_out", bus.rk_out, 128'd0);
    check_output("oor15_err", 128'(bus.rk_err), 128'd1);

    // Restart after valid with key 0
    bus.rk_idx = 4'd10;
    apply_stimulus(128'd0);
    check_output("z_valid_k", 128'(bus.key_valid), 128'd0);
    check_output("z_busy_k", 128'(bus.busy), 128'd1);
    check_output("z_read_k", bus.rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    check_output("z_read_k1_out", bus.rk_out, 128'd0);
    check_output("z_read_k1_err", 128'(bus.rk_err), 128'd1);
    wait_done("z");
    read_rk(4'd1);
    check_output("z_vec_rk1", bus.rk_out, 128'h62636363626363636263636362636363);
    read_rk(4'd10);
    check_output("z_vec_rk10", bus.rk_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Reset at k+5 (with a competing start) aborts the expansion
    key_rand = {$urandom, $urandom, $urandom, $urandom};
    apply_stimulus(key_rand);
    for (int i = 0; i < 4; i++) tick();
    rst       = 1'b1;
    bus.start = 1'b1;
    tick();
    check_output("abort_busy", 128'(bus.busy), 128'd0);
    check_output("abort_valid", 128'(bus.key_valid), 128'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i <= 10; i += 5) begin
      read_rk(4'(i));
      check_output($sformatf("abort_out%0d", i), bus.rk_out, 128'd0);
      check_output($sformatf("abort_err%0d", i), 128'(bus.rk_err), 128'd1);
    end
    apply_stimulus(key_a1);
    wait_done("post_abort");
    read_rk(4'd10);
    check_output("post_abort_rk10", bus.rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Random keys against the model
    for (int n = 0; n < 4; n++) begin
      key_rand = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus(key_rand);
      wait_done($sformatf("rnd%0d", n));
      check_all($sformatf("rnd%0d", n), key_rand);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
